comb_stack: RTL and testbench
=============================

# comb_stack

Parameterized LIFO storage for the stack-based combination datapath. It accepts `push`/`pop` strobes from the combination controller, stores `(n, m)` operands selected by the datapath stack mux, and returns popped words on a registered output. The controller's `ld_n`/`ld_m` in the following cycle load that output into the operand registers. It also reports `is_empty` (the controller's termination test), `is_full`, and sticky overflow/underflow errors for debug.

## Interface
- `DATA_W`, 8, width of one stack word
- `DEPTH`, 16, number of entries; power of two, at least 2
- `CNT_W`, $clog2(DEPTH)+1, width of `count` and `hwm`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `clr`  in  1  synchronous clear; empties the stack and clears the flags
- `push`  in  1  write `din` to the top of the stack this cycle
- `pop`  in  1  remove the top of the stack this cycle; the value appears on `dout` after the edge
- `din`  in  DATA_W  push data (datapath stack-mux output)
- `dout`  out  DATA_W  last popped word, registered
- `is_empty`  out  1  `count == 0`
- `is_full`  out  1  `count == DEPTH`
- `count`  out  CNT_W  current occupancy
- `hwm`  out  CNT_W  high-water mark of `count` since reset or `clr`
- `ovf`  out  1  sticky; a push was attempted while full
- `unf`  out  1  sticky; a pop was attempted while empty

## Operation
- Reset (async) and `clr` (sync) both force: `sp`/`count` = 0, `dout` = 0, `hwm` = 0, `ovf` = `unf` = 0, `is_empty` = 1, `is_full` = 0.
- `clr` has priority over `push`/`pop` in the same cycle.
- Stack memory contents are not reset.
- `sp` points to the next free slot. The top of stack is `mem[sp-1]`.
- **Push only, not full:** `mem[sp] <= din`, `sp <= sp+1`. `dout` is unchanged.
- **Push only, full:** no write, `sp` unchanged, `ovf <= 1`.
- **Pop only, not empty:** `dout <= mem[sp-1]`, `sp <= sp-1`.
- **Pop only, empty:** `dout` holds, `sp` unchanged, `unf <= 1`.
- **Push and pop, not empty (including full):** `dout <= mem[sp-1]`, then `mem[sp-1] <= din`. `sp` unchanged. No error is raised.
- **Push and pop, empty:** bypass; `dout <= din`, `sp` unchanged. No error is raised.
- `hwm <= max(hwm, next count)` every cycle.
- Errors are sticky until `rst` or `clr`.
- Status is combinational from registered `sp` only: `is_empty`, `is_full`, `count = sp`.
- `sp` never wraps. Overflow and underflow are suppressed, never wrapped.

## Timing
- Push and pop take effect on the rising edge where the strobe is sampled high.
- Pop-to-`dout` latency is 1 cycle. The controller asserts `pop` in one state and `ld_n`/`ld_m` in the next, so it samples `dout` exactly then.
- `dout` holds its value until the next effective pop, bypass, or clear.
- `is_empty` reflects the edge just taken. After the controller's final pop, `is_empty` = 1 is visible in the next cycle, in time for the controller's empty-check state.
- There is no back-pressure. Strobes are single-cycle and never stall, and `push`/`pop` may be high on consecutive cycles.
- Reset asserted mid-sequence takes effect immediately (async). The first usable edge is the one after `rst` deasserts.

## Structure
- Shared package `comb_pkg`:
  - default `DATA_W`/`DEPTH`
  - stack-mux select encodings `SEL_STK_M` = 2'd0, `SEL_STK_N` = 2'd1, `SEL_STK_DEC` = 2'd2
  - a `stk_word_t` typedef
- One natural sub-module, `comb_stack_mem`: DEPTH×DATA_W register array with one synchronous write port and one combinational read port at `sp-1`.
- `comb_stack` owns `sp`, `dout`, the flags, and `hwm`.

## Test plan
All scenarios use `DATA_W`=8, `DEPTH`=4.
- **Reset, then four pushes and four pops:** push 0x11, 0x22, 0x33, 0x44 → `count` 4, `is_full` 1. Pop four times → `dout` 0x44, 0x33, 0x22, 0x11, each one cycle after its pop. Then `is_empty` 1 and `hwm` 4.
- **Overflow:** fill to 4, push 0x55 → `ovf` 1, `count` stays 4. The next pop returns 0x44.
- **Underflow:** pop on an empty stack → `unf` 1, `dout` holds its prior value, `count` 0.
- **Simultaneous push and pop:** with stack [0x0A, 0x0B], push+pop with `din` 0x0C → `dout` 0x0B, `count` 2. The next pop yields 0x0C. With an empty stack, push+pop with `din` 0x77 → `dout` 0x77, `count` 0, no `unf`.
- **Clear:** with `count` 3 and `ovf` 1, assert `clr` together with `push` → `count` 0, `ovf` 0, `hwm` 0, `dout` 0, and no write.
- **Async reset:** assert `rst` mid-cycle after two pushes → outputs return to reset values before the next edge. Then run a C(4,2) stack trace driven by a controller model and confirm the final `is_empty` arrives in the cycle the controller checks it.

Source files
------------

// File: rtl/comb_pkg.sv
// comb_pkg: shared defaults, stack-mux select encodings and stack word type for the combination datapath
package comb_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  typedef enum logic [1:0] {
    SEL_STK_M   = 2'd0,
    SEL_STK_N   = 2'd1,
    SEL_STK_DEC = 2'd2
  } stk_sel_t;
  typedef logic [DATA_W_DEF-1:0] stk_word_t;
endpackage

// File: rtl/comb_stack_mem.sv
// comb_stack_mem: DEPTH x DATA_W register array; ports clk, we/waddr/wdata sync write, raddr/rdata comb read
module comb_stack_mem
  import comb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/comb_stack.sv
// comb_stack: LIFO with registered pop data; ports clk/rst/clr, push/pop/din in, dout/is_empty/is_full/count/hwm/ovf/unf out
module comb_stack
  import comb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              is_empty,
  output logic              is_full,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  hwm,
  output logic              ovf,
  output logic              unf
);
  localparam int AW = $clog2(DEPTH);
  logic [CNT_W-1:0]  sp, sp_nxt;
  logic [AW-1:0]     top, waddr;
  logic [DATA_W-1:0] rdata;
  logic              do_push, do_pop, swap, bypass, we;
  assign is_empty = sp == '0;
  assign is_full  = sp == CNT_W'(DEPTH);
  assign count    = sp;
  assign top      = AW'(sp - CNT_W'(1));
  assign do_push  = push & ~pop & ~is_full;
  assign do_pop   = pop & ~push & ~is_empty;
  assign swap     = push & pop & ~is_empty;
  assign bypass   = push & pop & is_empty;
  assign we       = ~clr & (do_push | swap);
  assign waddr    = do_push ? sp[AW-1:0] : top;
  always_comb
    sp_nxt = clr ? '0 : do_push ? sp + CNT_W'(1) : do_pop ? sp - CNT_W'(1) : sp;
  comb_stack_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (top),
    .rdata (rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sp   <= '0;
      dout <= '0;
      hwm  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      sp   <= sp_nxt;
      dout <= clr ? '0 : (do_pop | swap) ? rdata : bypass ? din : dout;
      hwm  <= clr ? '0 : sp_nxt > hwm ? sp_nxt : hwm;
      ovf  <= ~clr & (ovf | (push & ~pop & is_full));
      unf  <= ~clr & (unf | (pop & ~push & is_empty));
    end
endmodule

// File: tb/tb_comb_stack.sv
// tb_comb_stack: directed scoreboard bench for comb_stack at DATA_W=8, DEPTH=4
module tb_comb_stack;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       is_empty, is_full, ovf, unf;
  logic [2:0] count, hwm;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  logic [7:0] mdl [$];
  always #5 clk = ~clk;
  comb_stack #(.DATA_W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .dout     (dout),
    .is_empty (is_empty),
    .is_full  (is_full),
    .count    (count),
    .hwm      (hwm),
    .ovf      (ovf),
    .unf      (unf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic c, input logic ps, input logic pp, input logic [7:0] d);
    clr = c;
    push = ps;
    pop = pp;
    din = d;
    @(posedge clk);
    #1;
    clr = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    if (sb.size() > 0) chk("dout", dout, sb.pop_front());
  endtask
  task automatic popx(input logic [7:0] e);
    sb.push_back(e);
    cyc(0, 0, 1, 8'h00);
  endtask
  initial begin
    int result;
    logic [7:0] w;
    logic [3:0] n, m;
    #12 rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", is_empty, 1);
    chk("rst_full", is_full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_hwm", hwm, 0);
    chk("rst_flags", {ovf, unf}, 0);
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    chk("push_dout_hold", dout, 0);
    cyc(0, 1, 0, 8'h33);
    cyc(0, 1, 0, 8'h44);
    chk("fill_count", count, 4);
    chk("fill_full", is_full, 1);
    popx(8'h44);
    popx(8'h33);
    popx(8'h22);
    popx(8'h11);
    chk("drain_empty", is_empty, 1);
    chk("drain_hwm", hwm, 4);
    chk("drain_unf", unf, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 8'(i * 'h11));
    cyc(0, 1, 0, 8'h55);
    chk("ovf_flag", ovf, 1);
    chk("ovf_count", count, 4);
    popx(8'h44);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_pop_count", count, 3);
    cyc(1, 1, 0, 8'h99);
    chk("clr_count", count, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_hwm", hwm, 0);
    chk("clr_dout", dout, 0);
    chk("clr_empty", is_empty, 1);
    cyc(0, 1, 0, 8'h5A);
    popx(8'h5A);
    popx(8'h5A);
    chk("unf_flag", unf, 1);
    chk("unf_count", count, 0);
    cyc(1, 0, 0, 8'h00);
    chk("clr_unf", unf, 0);
    cyc(0, 1, 0, 8'h0A);
    cyc(0, 1, 0, 8'h0B);
    sb.push_back(8'h0B);
    cyc(0, 1, 1, 8'h0C);
    chk("swap_count", count, 2);
    popx(8'h0C);
    popx(8'h0A);
    sb.push_back(8'h77);
    cyc(0, 1, 1, 8'h77);
    chk("bypass_count", count, 0);
    chk("bypass_unf", unf, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 8'(i));
    sb.push_back(8'h04);
    cyc(0, 1, 1, 8'h09);
    chk("swap_full_count", count, 4);
    chk("swap_full_ovf", ovf, 0);
    popx(8'h09);
    popx(8'h03);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'hA1);
    cyc(0, 1, 0, 8'hA2);
    popx(8'hA2);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    chk("arst_empty", is_empty, 1);
    chk("arst_hwm", hwm, 0);
    @(negedge clk) rst = 1'b0;
    // C(4,2) trace: each word packs n (high nibble) and m (low nibble)
    result = 0;
    mdl.push_back(8'h42);
    cyc(0, 1, 0, 8'h42);
    for (int it = 0; it < 64 && mdl.size() > 0; it++) begin
      w = mdl.pop_back();
      sb.push_back(w);
      cyc(0, 0, 1, 8'h00);
      chk("trace_empty", is_empty, mdl.size() == 0);
      n = w[7:4];
      m = w[3:0];
      if (m == 0 || m == n) result++;
      else begin
        mdl.push_back({n - 4'd1, m - 4'd1});
        cyc(0, 1, 0, {n - 4'd1, m - 4'd1});
        mdl.push_back({n - 4'd1, m});
        cyc(0, 1, 0, {n - 4'd1, m});
      end
    end
    chk("trace_done", mdl.size(), 0);
    chk("trace_result", result, 6);
    chk("trace_final_empty", is_empty, 1);
    chk("trace_hwm", hwm, 3);
    chk("trace_flags", {ovf, unf}, 0);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
